// File: rtl/tutor_sched.sv
// tutor_sched: song-tutor scheduler for the FPGA piano.
// Owns the free-play / tutor mode, picks which song tutor runs and holds
// the rest in reset. Routes the active tutor's hint LEDs to the board,
// blinks the hint after an idle timeout, counts presses and latches a score.
//
// state  | meaning
// -------+-----------------------------------------------------------
// FREE   | free play, all tutors held in reset, board LEDs dark
// SELECT | choosing a song, one-hot LED shows sel
// PLAY   | tutor sel released, hint LEDs routed, presses counted
// DONE   | celebrate blink for CELEB_CYCLES, then back to SELECT
//
// Ports:
//   clk_i        system clock
//   rst_i        asynchronous active-high reset
//   note_i       current key code, NOTE_NONE = no key
//   mode_btn_i   pulse: toggle free/tutor (highest priority)
//   song_btn_i   pulse: next song in SELECT, abort in PLAY
//   start_btn_i  pulse: start selected song
//   tutor_led_i  hint LEDs, tutor i on [8i+7:8i]
//   song_done_i  completion pulse per tutor
//   tutor_rst_o  1 holds tutor i in reset
//   free_mode_o  1 in FREE
//   sel_o        selected song index
//   led_o        board LEDs
//   presses_o    press count of the current attempt
//   score_o      press count latched at last completion
module tutor_sched #(
    parameter int         NUM_SONGS      = 4,
    parameter int         TIMEOUT_CYCLES = 50_000_000,
    parameter int         BLINK_CYCLES   = 12_500_000,
    parameter int         CELEB_CYCLES   = 100_000_000,
    parameter logic [3:0] NOTE_NONE      = 4'd0
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [3:0]             note_i,
    input  logic                   mode_btn_i,
    input  logic                   song_btn_i,
    input  logic                   start_btn_i,
    input  logic [8*NUM_SONGS-1:0] tutor_led_i,
    input  logic [NUM_SONGS-1:0]   song_done_i,
    output logic [NUM_SONGS-1:0]   tutor_rst_o,
    output logic                   free_mode_o,
    output logic [2:0]             sel_o,
    output logic [7:0]             led_o,
    output logic [7:0]             presses_o,
    output logic [7:0]             score_o
);

    localparam int IW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam int BW = $clog2(BLINK_CYCLES) + 1;
    localparam int CW = $clog2(CELEB_CYCLES) + 1;

    localparam logic [IW-1:0] IDLE_MAX   = IW'(TIMEOUT_CYCLES);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 1);
    localparam logic [CW-1:0] CELEB_LAST = CW'(CELEB_CYCLES - 1);
    localparam logic [2:0]    SEL_LAST   = 3'(NUM_SONGS - 1);

    typedef enum logic [1:0] {S_FREE, S_SELECT, S_PLAY, S_DONE} state_t;

    state_t               state_q, state_d;
    logic [2:0]           sel_q, sel_d;
    logic [NUM_SONGS-1:0] tutor_rst_q, tutor_rst_d;
    logic                 free_q, free_d;
    logic [7:0]           led_q, led_d;
    logic [7:0]           presses_q, presses_d;
    logic [7:0]           score_q, score_d;
    logic [3:0]           prev_note_q;
    logic [IW-1:0]        idle_q, idle_d;
    logic [BW-1:0]        blink_cnt_q, blink_cnt_d;
    logic                 phase_q, phase_d;
    logic [CW-1:0]        celeb_q, celeb_d;

    logic [7:0] hint;
    logic       done_sel;
    logic       press;
    logic       blink_run;
    logic       enter_play;
    logic [7:0] presses_inc;

    always_comb begin
        hint     = '0;
        done_sel = 1'b0;
        for (int i = 0; i < NUM_SONGS; i++) begin
            if (sel_q == 3'(i)) begin
                hint     = tutor_led_i[8*i +: 8];
                done_sel = song_done_i[i];
            end
        end
    end

    assign press = (note_i != NOTE_NONE) && (prev_note_q == NOTE_NONE);

    // A press suppresses the blink in its own cycle so the hint comes back
    // on the very next LED update rather than one cycle later.
    assign blink_run = ((state_q == S_PLAY) && (idle_q == IDLE_MAX) && !press)
                     || (state_q == S_DONE);

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_FREE;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
        end
    end

    // Next-state logic; mode_btn overrides everything
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        if (mode_btn_i) begin
            state_d = (state_q == S_FREE) ? S_SELECT : S_FREE;
        end else begin
            unique case (state_q)
                S_FREE: ;
                S_SELECT: begin
                    if (start_btn_i)
                        state_d = S_PLAY;
                    else if (song_btn_i)
                        sel_d = (sel_q == SEL_LAST) ? 3'd0 : sel_q + 3'd1;
                end
                S_PLAY: begin
                    if (done_sel)
                        state_d = S_DONE;
                    else if (song_btn_i)
                        state_d = S_SELECT;
                end
                S_DONE: begin
                    if (celeb_q == CELEB_LAST)
                        state_d = S_SELECT;
                end
                default: state_d = S_FREE;
            endcase
        end
    end

    // Output logic: registered outputs follow the next state, LEDs the current
    always_comb begin
        tutor_rst_d = '1;
        if (state_d == S_PLAY) begin
            for (int i = 0; i < NUM_SONGS; i++)
                if (sel_d == 3'(i)) tutor_rst_d[i] = 1'b0;
        end
        free_d = (state_d == S_FREE);
        led_d  = 8'h00;
        unique case (state_q)
            S_FREE:   led_d = 8'h00;
            S_SELECT: led_d = 8'd1 << sel_q;
            S_PLAY:   led_d = (blink_run && !phase_q) ? 8'h00 : hint;
            S_DONE:   led_d = {8{phase_q}};
            default:  led_d = 8'h00;
        endcase
    end

    assign enter_play  = (state_q != S_PLAY) && (state_d == S_PLAY);
    assign presses_inc = (press && presses_q != 8'hFF) ? presses_q + 8'd1 : presses_q;

    always_comb begin
        presses_d = presses_q;
        score_d   = score_q;
        idle_d    = idle_q;
        if (enter_play) begin
            presses_d = '0;
            idle_d    = '0;
        end else if (state_q == S_PLAY) begin
            presses_d = presses_inc;
            if (press)
                idle_d = '0;
            else if (idle_q != IDLE_MAX)
                idle_d = idle_q + 1'b1;
        end
        if (state_q == S_PLAY && !mode_btn_i && done_sel)
            score_d = presses_inc;

        // Phase restarts at 1 whenever blinking starts or the state changes
        if (state_d != state_q || !blink_run) begin
            blink_cnt_d = '0;
            phase_d     = 1'b1;
        end else if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d = '0;
            phase_d     = !phase_q;
        end else begin
            blink_cnt_d = blink_cnt_q + 1'b1;
            phase_d     = phase_q;
        end

        celeb_d = (state_q == S_DONE && state_d == S_DONE) ? celeb_q + 1'b1 : '0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tutor_rst_q <= '1;
            free_q      <= 1'b1;
            led_q       <= '0;
            presses_q   <= '0;
            score_q     <= '0;
            prev_note_q <= NOTE_NONE;
            idle_q      <= '0;
            blink_cnt_q <= '0;
            phase_q     <= 1'b1;
            celeb_q     <= '0;
        end else begin
            tutor_rst_q <= tutor_rst_d;
            free_q      <= free_d;
            led_q       <= led_d;
            presses_q   <= presses_d;
            score_q     <= score_d;
            prev_note_q <= note_i;
            idle_q      <= idle_d;
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
            celeb_q     <= celeb_d;
        end
    end

    assign tutor_rst_o = tutor_rst_q;
    assign free_mode_o = free_q;
    assign sel_o       = sel_q;
    assign led_o       = led_q;
    assign presses_o   = presses_q;
    assign score_o     = score_q;

endmodule

// File: tb/tb_tutor_sched.sv
module tb_tutor_sched;

    localparam int NS    = 4;
    localparam int TMO   = 8;
    localparam int BLINK = 2;
    localparam int CELEB = 6;

    localparam int M_FREE = 0, M_SELECT = 1, M_PLAY = 2, M_DONE = 3;
    localparam logic [3:0] NONE = 4'd0, KEY_E = 4'd5, KEY_F = 4'd6;

    logic        clk = 1'b0;
    logic        rst;
    logic        mode, song, start;
    logic [3:0]  note;
    logic [3:0]  done;
    logic [31:0] tled;

    logic [3:0]  tutor_rst_o;
    logic        free_mode_o;
    logic [2:0]  sel_o;
    logic [7:0]  led_o, presses_o, score_o;

    tutor_sched #(
        .NUM_SONGS(NS), .TIMEOUT_CYCLES(TMO), .BLINK_CYCLES(BLINK),
        .CELEB_CYCLES(CELEB), .NOTE_NONE(NONE)
    ) dut (
        .clk_i(clk), .rst_i(rst), .note_i(note), .mode_btn_i(mode),
        .song_btn_i(song), .start_btn_i(start), .tutor_led_i(tled),
        .song_done_i(done), .tutor_rst_o(tutor_rst_o), .free_mode_o(free_mode_o),
        .sel_o(sel_o), .led_o(led_o), .presses_o(presses_o), .score_o(score_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Behavioural model: plain integers, elapsed-time arithmetic for blinking
    int         ms, msel, mpresses, mscore, midle, mblink_t, mdone_t;
    logic [3:0] mprev_note;
    logic [7:0] mled;
    logic [3:0] mrst;
    logic       mfree;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        ms = M_FREE; msel = 0; mpresses = 0; mscore = 0; midle = 0;
        mblink_t = 0; mdone_t = 0; mprev_note = NONE;
        mled = 8'h00; mrst = 4'hF; mfree = 1'b1;
    endtask

    task automatic model_step();
        logic       press, blinking;
        logic [7:0] hint, nled;
        int         ns, nsel, pinc;
        press    = (note != NONE) && (mprev_note == NONE);
        hint     = tled[msel*8 +: 8];
        blinking = (ms == M_PLAY) && (midle >= TMO) && !press;
        case (ms)
            M_SELECT: nled = 8'(1 << msel);
            M_PLAY:   nled = (blinking && ((mblink_t / BLINK) % 2 == 1)) ? 8'h00 : hint;
            M_DONE:   nled = ((mdone_t / BLINK) % 2 == 0) ? 8'hFF : 8'h00;
            default:  nled = 8'h00;
        endcase
        ns = ms; nsel = msel;
        if (mode) ns = (ms == M_FREE) ? M_SELECT : M_FREE;
        else if (ms == M_SELECT) begin
            if (start) ns = M_PLAY;
            else if (song) nsel = (msel + 1) % NS;
        end else if (ms == M_PLAY) begin
            if (done[msel]) ns = M_DONE;
            else if (song) ns = M_SELECT;
        end else if (ms == M_DONE) begin
            if (mdone_t == CELEB - 1) ns = M_SELECT;
        end
        pinc = (press && mpresses < 255) ? mpresses + 1 : mpresses;
        if (ms == M_PLAY && !mode && done[msel]) mscore = pinc;
        if (ns == M_PLAY && ms != M_PLAY) begin
            mpresses = 0; midle = 0;
        end else if (ms == M_PLAY) begin
            mpresses = pinc;
            midle = press ? 0 : midle + 1;
        end
        mblink_t = (ms == M_PLAY && ns == M_PLAY && blinking) ? mblink_t + 1 : 0;
        mdone_t  = (ms == M_DONE && ns == M_DONE) ? mdone_t + 1 : 0;
        mprev_note = note;
        mrst = 4'hF;
        if (ns == M_PLAY) mrst[nsel] = 1'b0;
        mfree = (ns == M_FREE);
        mled  = nled;
        ms = ns; msel = nsel;
    endtask

    task automatic compare_all(input string tag);
        chk({tag, ".led"},     led_o,       mled);
        chk({tag, ".rst"},     tutor_rst_o, mrst);
        chk({tag, ".free"},    free_mode_o, mfree);
        chk({tag, ".sel"},     sel_o,       msel);
        chk({tag, ".presses"}, presses_o,   mpresses);
        chk({tag, ".score"},   score_o,     mscore);
    endtask

    task automatic step(input logic m, input logic s, input logic st,
                        input logic [3:0] n, input logic [3:0] d);
        @(negedge clk);
        mode = m; song = s; start = st; note = n; done = d;
        model_step();
        @(posedge clk);
        #1;
        compare_all("model");
    endtask

    task automatic async_reset();
        @(negedge clk);
        mode = 1'b0; song = 1'b0; start = 1'b0; note = NONE; done = 4'h0;
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk("areset.led",  led_o, 8'h00);
        chk("areset.rst",  tutor_rst_o, 4'hF);
        chk("areset.free", free_mode_o, 1'b1);
        chk("areset.sel",  sel_o, 3'd0);
        chk("areset.score", score_o, 8'd0);
        chk("areset.presses", presses_o, 8'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        logic       m, s, st;
        logic [3:0] n, d;
        logic       efree;
        logic [2:0] esel;
        logic [3:0] erst;
        logic [7:0] eled;
    } vec_t;

    vec_t       tbl[10];
    logic [7:0] blink_pat[12];
    logic [7:0] done_pat[6];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{1'b1, 1'b0, 1'b0, NONE, 4'h0, 1'b0, 3'd0, 4'hF, 8'h00};
        tbl[1] = '{1'b0, 1'b1, 1'b0, NONE, 4'h0, 1'b0, 3'd1, 4'hF, 8'h01};
        tbl[2] = '{1'b0, 1'b1, 1'b0, NONE, 4'h0, 1'b0, 3'd2, 4'hF, 8'h02};
        tbl[3] = '{1'b0, 1'b1, 1'b0, NONE, 4'h0, 1'b0, 3'd3, 4'hF, 8'h04};
        tbl[4] = '{1'b0, 1'b1, 1'b0, NONE, 4'h0, 1'b0, 3'd0, 4'hF, 8'h08};
        tbl[5] = '{1'b0, 1'b1, 1'b0, NONE, 4'h0, 1'b0, 3'd1, 4'hF, 8'h01};
        tbl[6] = '{1'b0, 1'b0, 1'b0, NONE, 4'h0, 1'b0, 3'd1, 4'hF, 8'h02};
        tbl[7] = '{1'b0, 1'b1, 1'b0, NONE, 4'h0, 1'b0, 3'd2, 4'hF, 8'h02};
        tbl[8] = '{1'b0, 1'b1, 1'b1, NONE, 4'h0, 1'b0, 3'd2, 4'hB, 8'h04};
        tbl[9] = '{1'b0, 1'b0, 1'b0, NONE, 4'h0, 1'b0, 3'd2, 4'hB, 8'h04};
        blink_pat = '{8'h04, 8'h04, 8'h04, 8'h04, 8'h04, 8'h04, 8'h04, 8'h04,
                      8'h00, 8'h00, 8'h04, 8'h04};
        done_pat  = '{8'hFF, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'hFF};

        rst = 1'b1; mode = 1'b0; song = 1'b0; start = 1'b0;
        note = NONE; done = 4'h0; tled = 32'h1104_2233;
        model_reset();
        #12;
        chk("reset.led", led_o, 8'h00);
        chk("reset.rst", tutor_rst_o, 4'hF);
        chk("reset.free", free_mode_o, 1'b1);
        chk("reset.sel", sel_o, 3'd0);
        chk("reset.presses", presses_o, 8'd0);
        chk("reset.score", score_o, 8'd0);
        @(negedge clk);
        rst = 1'b0;

        // Select with wrap, then start+song together
        for (int i = 0; i < 10; i++) begin
            step(tbl[i].m, tbl[i].s, tbl[i].st, tbl[i].n, tbl[i].d);
            chk($sformatf("tbl%0d.free", i), free_mode_o, tbl[i].efree);
            chk($sformatf("tbl%0d.sel", i),  sel_o,       tbl[i].esel);
            chk($sformatf("tbl%0d.rst", i),  tutor_rst_o, tbl[i].erst);
            chk($sformatf("tbl%0d.led", i),  led_o,       tbl[i].eled);
        end

        // Press counting; a held key counts once
        step(0, 0, 0, KEY_E, 0); step(0, 0, 0, NONE, 0);
        step(0, 0, 0, KEY_E, 0); step(0, 0, 0, NONE, 0);
        step(0, 0, 0, KEY_F, 0); step(0, 0, 0, NONE, 0);
        chk("presses.three", presses_o, 8'd3);
        step(0, 0, 0, KEY_E, 0); step(0, 0, 0, KEY_E, 0); step(0, 0, 0, KEY_E, 0);
        chk("presses.held", presses_o, 8'd4);

        // Idle blink, then a press restores the steady hint
        for (int k = 0; k < 12; k++) begin
            step(0, 0, 0, NONE, 0);
            chk($sformatf("idle_blink%0d", k), led_o, blink_pat[k]);
        end
        step(0, 0, 0, KEY_E, 0);
        chk("press_unblinks", led_o, 8'h04);
        for (int k = 0; k < 9; k++) begin
            step(0, 0, 0, NONE, 0);
            chk($sformatf("idle_restart%0d", k), led_o, 8'h04);
        end

        // Reach 7 presses, ignore unselected done, then complete
        step(0, 0, 0, KEY_E, 0); step(0, 0, 0, NONE, 0); step(0, 0, 0, KEY_F, 0);
        chk("presses.seven", presses_o, 8'd7);
        step(0, 0, 0, KEY_F, 4'b0001);
        chk("done_other.rst", tutor_rst_o, 4'hB);
        step(0, 0, 0, KEY_F, 4'b0100);
        chk("done.score", score_o, 8'd7);
        chk("done.rst", tutor_rst_o, 4'hF);
        for (int k = 0; k < CELEB; k++) begin
            step(0, k == 1, k == 1, NONE, 0);
            chk($sformatf("celebrate%0d", k), led_o, done_pat[k]);
        end
        chk("celebrate_end.sel", sel_o, 3'd2);
        chk("celebrate_end.free", free_mode_o, 1'b0);
        step(0, 0, 0, NONE, 0);
        chk("back_select.led", led_o, 8'h04);

        // mode_btn beats song_done: no score latch
        step(0, 0, 1, NONE, 0);
        chk("replay.rst", tutor_rst_o, 4'hB);
        chk("replay.presses", presses_o, 8'd0);
        step(1, 0, 0, NONE, 4'b0100);
        chk("mode_vs_done.free", free_mode_o, 1'b1);
        chk("mode_vs_done.score", score_o, 8'd7);

        // Press counter saturation and score latch at 255
        step(1, 0, 0, NONE, 0);
        step(0, 0, 1, NONE, 0);
        for (int k = 0; k < 260; k++) begin
            step(0, 0, 0, KEY_E, 0);
            step(0, 0, 0, NONE, 0);
        end
        chk("presses.sat", presses_o, 8'd255);
        step(0, 0, 0, KEY_E, 4'b0100);
        chk("score.sat", score_o, 8'd255);
        step(0, 0, 0, NONE, 0);
        chk("mid_done.led", led_o, 8'hFF);
        async_reset();

        // Randomised traffic against the model
        for (int i = 0; i < 3000; i++) begin
            logic       rm, rs, rst_b;
            logic [3:0] rd;
            logic [3:0] rn;
            rm = ($urandom_range(0, 39) == 0);
            rs = ($urandom_range(0, 9) == 0);
            rst_b = ($urandom_range(0, 5) == 0);
            rn = note;
            if ($urandom_range(0, 3) == 0)
                rn = ($urandom_range(0, 2) == 0) ? NONE : 4'($urandom_range(1, 12));
            for (int b = 0; b < NS; b++) rd[b] = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 15) == 0) tled = $urandom();
            step(rm, rs, rst_b, rn, rd);
            if (i == 1500) async_reset();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
